// File: rtl/pio_edge_irq_reader.sv
`default_nettype none
// ============================================================================
// Module   : pio_edge_irq_reader
// Brief    : Avalon-MM master that programs an edge-capture PIO irq mask, services
//            its irq (read edge_capture, read data, clear edge_capture) and queues
//            each event as {flags,data} on a FWFT valid/ready stream.
//            Optional per-event timestamp: define PIO_EDGE_IRQ_READER_TIMESTAMP_EN.
// Revision : 1.0 - initial release
// ============================================================================
module pio_edge_irq_reader #(
    parameter int DW           = 32,
    parameter int FIFO_DEPTH   = 4,
    parameter int READ_LATENCY = 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [DW-1:0] cfg_mask,
    input  logic          cfg_mask_wr,
    input  logic          en,
    output logic [1:0]    address,
    output logic          chipselect,
    output logic          write_n,
    output logic [DW-1:0] writedata,
    input  logic [DW-1:0] readdata,
    input  logic          irq,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_flags,
    output logic [DW-1:0] out_data,
`ifdef PIO_EDGE_IRQ_READER_TIMESTAMP_EN
    output logic [DW-1:0] out_ts,
`endif
    output logic          busy,
    output logic          full_stall
);

    localparam int c_AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int c_CW = (READ_LATENCY > 0) ? $clog2(READ_LATENCY + 1) : 1;

    localparam logic [c_CW-1:0] c_LAT   = c_CW'(READ_LATENCY);
    localparam logic [c_AW:0]   c_DEPTH = (c_AW + 1)'(FIFO_DEPTH);

    localparam logic [1:0] c_ADDR_DATA = 2'd0;
    localparam logic [1:0] c_ADDR_MASK = 2'd2;
    localparam logic [1:0] c_ADDR_CAP  = 2'd3;

    localparam logic [2:0] c_S_INIT   = 3'd0;
    localparam logic [2:0] c_S_IDLE   = 3'd1;
    localparam logic [2:0] c_S_MASK   = 3'd2;
    localparam logic [2:0] c_S_RD_CAP = 3'd3;
    localparam logic [2:0] c_S_RD_DAT = 3'd4;
    localparam logic [2:0] c_S_CLR    = 3'd5;
    localparam logic [2:0] c_S_PUSH   = 3'd6;

    logic [2:0]      r_state, w_state_next;
    logic [c_CW-1:0] r_cnt, w_cnt_next;
    logic [DW-1:0]   r_flags, r_data;
    logic            r_mask_req;
    logic [DW-1:0]   r_mask_val;

    logic [1:0]      r_address, w_address_next;
    logic            r_chipselect, w_cs_next;
    logic            r_write_n, w_write_n_next;
    logic [DW-1:0]   r_writedata, w_writedata_next;
    logic            r_busy;

    logic            w_mask_taken;
    logic            w_cap_flags;
    logic            w_cap_data;
    logic            w_push;
    logic            w_start;

    logic [c_AW-1:0] r_wr_ptr, r_rd_ptr;
    logic [c_AW:0]   r_count;
    logic            w_full, w_empty, w_pop, w_push_ok;
    logic [DW-1:0]   r_mem_flags [FIFO_DEPTH];
    logic [DW-1:0]   r_mem_data  [FIFO_DEPTH];

    assign w_full    = (r_count == c_DEPTH);
    assign w_empty   = (r_count == '0);
    assign w_pop     = ~w_empty & out_ready;
    assign w_push_ok = w_push & (~w_full | w_pop);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= c_S_INIT;
            r_cnt        <= '0;
            r_flags      <= '0;
            r_data       <= '0;
            r_address    <= '0;
            r_chipselect <= 1'b0;
            r_write_n    <= 1'b1;
            r_writedata  <= '0;
            r_busy       <= 1'b1;
        end else begin
            r_state      <= w_state_next;
            r_cnt        <= w_cnt_next;
            r_address    <= w_address_next;
            r_chipselect <= w_cs_next;
            r_write_n    <= w_write_n_next;
            r_writedata  <= w_writedata_next;
            r_busy       <= (w_state_next != c_S_IDLE);
            if (w_cap_flags) r_flags <= readdata;
            if (w_cap_data)  r_data  <= readdata;
        end
    end

    // A pulse always wins over the clear so a request arriving while the
    // previous one executes is not dropped.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_mask_req <= 1'b1;
            r_mask_val <= '0;
        end else if (cfg_mask_wr) begin
            r_mask_req <= 1'b1;
            r_mask_val <= cfg_mask;
        end else if (w_mask_taken) begin
            r_mask_req <= 1'b0;
        end
    end

    // Bus outputs are registered from the transition, so each state is also
    // the bus phase that is on the wires while the FSM sits in it.
    always_comb begin
        w_state_next     = r_state;
        w_cnt_next       = r_cnt;
        w_address_next   = r_address;
        w_cs_next        = 1'b0;
        w_write_n_next   = 1'b1;
        w_writedata_next = r_writedata;
        w_mask_taken     = 1'b0;
        w_cap_flags      = 1'b0;
        w_cap_data       = 1'b0;
        w_push           = 1'b0;
        w_start          = 1'b0;
        case (r_state)
            c_S_INIT: begin
                w_state_next     = c_S_MASK;
                w_cs_next        = 1'b1;
                w_write_n_next   = 1'b0;
                w_address_next   = c_ADDR_MASK;
                w_writedata_next = cfg_mask;
                w_mask_taken     = 1'b1;
            end
            c_S_IDLE: begin
                if (r_mask_req) begin
                    w_state_next     = c_S_MASK;
                    w_cs_next        = 1'b1;
                    w_write_n_next   = 1'b0;
                    w_address_next   = c_ADDR_MASK;
                    w_writedata_next = r_mask_val;
                    w_mask_taken     = 1'b1;
                end else if (en && irq && !w_full) begin
                    w_state_next   = c_S_RD_CAP;
                    w_cs_next      = 1'b1;
                    w_address_next = c_ADDR_CAP;
                    w_cnt_next     = '0;
                    w_start        = 1'b1;
                end
            end
            c_S_MASK: begin
                w_state_next = c_S_IDLE;
            end
            c_S_RD_CAP: begin
                w_cs_next = 1'b1;
                if (r_cnt == c_LAT) begin
                    w_cap_flags    = 1'b1;
                    w_state_next   = c_S_RD_DAT;
                    w_address_next = c_ADDR_DATA;
                    w_cnt_next     = '0;
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            c_S_RD_DAT: begin
                w_cs_next = 1'b1;
                if (r_cnt == c_LAT) begin
                    w_cap_data       = 1'b1;
                    w_state_next     = c_S_CLR;
                    w_write_n_next   = 1'b0;
                    w_address_next   = c_ADDR_CAP;
                    w_writedata_next = r_flags;
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            c_S_CLR: begin
                w_state_next = c_S_PUSH;
            end
            c_S_PUSH: begin
                w_push       = 1'b1;
                w_state_next = c_S_IDLE;
            end
            default: begin
                w_state_next = c_S_INIT;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)     r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push_ok, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem_flags[r_wr_ptr] <= r_flags;
            r_mem_data[r_wr_ptr]  <= r_data;
        end
    end

`ifdef PIO_EDGE_IRQ_READER_TIMESTAMP_EN
    logic [DW-1:0] r_ts_cnt;
    logic [DW-1:0] r_ts_evt;
    logic [DW-1:0] r_mem_ts [FIFO_DEPTH];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ts_cnt <= '0;
            r_ts_evt <= '0;
        end else begin
            r_ts_cnt <= r_ts_cnt + 1'b1;
            if (w_start) r_ts_evt <= r_ts_cnt;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push_ok) r_mem_ts[r_wr_ptr] <= r_ts_evt;
    end

    assign out_ts = r_mem_ts[r_rd_ptr];
`endif

    assign address    = r_address;
    assign chipselect = r_chipselect;
    assign write_n    = r_write_n;
    assign writedata  = r_writedata;
    assign busy       = r_busy;
    assign out_valid  = ~w_empty;
    assign out_flags  = r_mem_flags[r_rd_ptr];
    assign out_data   = r_mem_data[r_rd_ptr];
    // Deferred service is visible while the level irq waits on a full FIFO.
    assign full_stall = (r_state == c_S_IDLE) & en & irq & w_full;

endmodule
`default_nettype wire
